// File: rtl/mlp_pkg.sv
// mlp_pkg: shared state encoding, parameter defaults, byte-lane constants
// and the unsigned-by-signed byte multiply used by the 7-2-1 serial MLP core.
package mlp_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_L1,
      S_ACT1,
      S_L2,
      S_ACT2
   } state_e;

   localparam int unsigned ACC_W_DEF    = 20;
   localparam int unsigned QSHIFT_DEF   = 4;

   localparam int unsigned N_IN         = 7;
   localparam int unsigned L1_BIAS_LANE = 7;
   localparam int unsigned L2_BIAS_LANE = 2;

   // u8 x s8 product; the exact result always fits a signed 17-bit value
   function automatic logic signed [16:0] mul_u8s8(input logic [7:0] x, input logic [7:0] w);
      logic signed [16:0] xe;
      logic signed [16:0] we;
      xe = {9'b0, x};
      we = {{9{w[7]}}, w};
      return xe * we;
   endfunction

endpackage

// File: rtl/mlp_act.sv
// mlp_act: neuron activation -- ReLU, requantising right shift, then byte
// reduction. Build option MLP_CORE_SATURATE_EN clamps values above 255;
// without it the low byte is kept and the result wraps.
module mlp_act
   import mlp_pkg::*;
#(
   parameter int unsigned ACC_W  = ACC_W_DEF,
   parameter int unsigned QSHIFT = QSHIFT_DEF
) (
   input  logic [ACC_W-1:0] acc_i,
   output logic [7:0]       act_o
);

   logic [ACC_W-1:0] shifted;

   // negative accumulators give 0; otherwise shift and reduce to a byte
   always_comb begin
      shifted = acc_i >> QSHIFT;
      act_o   = '0;
      if (!acc_i[ACC_W-1]) begin
`ifdef MLP_CORE_SATURATE_EN
         act_o = (|shifted[ACC_W-1:8]) ? 8'hFF : shifted[7:0];
`else
         act_o = shifted[7:0];
`endif
      end
   end

`ifndef MLP_CORE_SATURATE_EN
   logic unused_hi;
   assign unused_hi = ^shifted[ACC_W-1:8];
`endif

endmodule

// File: rtl/mlp_serial_core.sv
// mlp_serial_core: serial 7-2-1 perceptron answering the start/done batch
// protocol. One request takes 7 clocks from the capture edge to done.
// Build option MLP_CORE_SATURATE_EN (applied in mlp_act) selects clamping
// instead of wrapping at every neuron output.
module mlp_serial_core
   import mlp_pkg::*;
#(
   parameter int unsigned QSHIFT = QSHIFT_DEF,
   parameter int unsigned ACC_W  = ACC_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [55:0] data_in,
   input  logic [63:0] data_weight_1_1,
   input  logic [63:0] data_weight_1_2,
   input  logic [23:0] data_weight_2_1,
   output logic [7:0]  data_out,
   output logic        done,
   output logic        busy
);

   state_e              state_q, state_d;
   logic [1:0]          p_q, p_d;
   logic                start_q;
   logic [8*N_IN-1:0]   x_q, x_d;
   logic [63:0]         w11_q, w11_d, w12_q, w12_d;
   logic [23:0]         w21_q, w21_d;
   logic [ACC_W-1:0]    acc0_q, acc0_d, acc1_q, acc1_d, acc2_q, acc2_d;
   logic [7:0]          h0_q, h0_d, h1_q, h1_d, out_q, out_d;
   logic                done_q, done_d;

   logic [7:0]          h0_act, h1_act, out_act;
   logic [63:0]         x_pad;
   logic [2:0]          lane_lo, lane_hi;

   function automatic logic [ACC_W-1:0] sext8(input logic [7:0] b);
      return {{(ACC_W-8){b[7]}}, b};
   endfunction

   function automatic logic [ACC_W-1:0] sext17(input logic [16:0] v);
      return {{(ACC_W-17){v[16]}}, v};
   endfunction

   mlp_act #(.ACC_W(ACC_W), .QSHIFT(QSHIFT)) u_act_h0 (.acc_i(acc0_q), .act_o(h0_act));
   mlp_act #(.ACC_W(ACC_W), .QSHIFT(QSHIFT)) u_act_h1 (.acc_i(acc1_q), .act_o(h1_act));
   mlp_act #(.ACC_W(ACC_W), .QSHIFT(QSHIFT)) u_act_o  (.acc_i(acc2_q), .act_o(out_act));

   // next-state and datapath updates for the request sequence
   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      x_d     = x_q;
      w11_d   = w11_q;
      w12_d   = w12_q;
      w21_d   = w21_q;
      acc0_d  = acc0_q;
      acc1_d  = acc1_q;
      acc2_d  = acc2_q;
      h0_d    = h0_q;
      h1_d    = h1_q;
      out_d   = out_q;
      done_d  = 1'b0;
      // lane 7 of the padded input is the non-existent x7, so the last
      // pair's second product is always zero
      x_pad   = {{(64-8*N_IN){1'b0}}, x_q};
      lane_lo = {p_q, 1'b0};
      lane_hi = {p_q, 1'b1};

      unique case (state_q)
         S_IDLE: begin
            if (start && !start_q) begin
               x_d     = data_in;
               w11_d   = data_weight_1_1;
               w12_d   = data_weight_1_2;
               w21_d   = data_weight_2_1;
               acc0_d  = sext8(data_weight_1_1[8*L1_BIAS_LANE +: 8]);
               acc1_d  = sext8(data_weight_1_2[8*L1_BIAS_LANE +: 8]);
               p_d     = '0;
               state_d = S_L1;
            end
         end
         S_L1: begin
            acc0_d = acc0_q
                   + sext17(mul_u8s8(x_pad[8*lane_lo +: 8], w11_q[8*lane_lo +: 8]))
                   + sext17(mul_u8s8(x_pad[8*lane_hi +: 8], w11_q[8*lane_hi +: 8]));
            acc1_d = acc1_q
                   + sext17(mul_u8s8(x_pad[8*lane_lo +: 8], w12_q[8*lane_lo +: 8]))
                   + sext17(mul_u8s8(x_pad[8*lane_hi +: 8], w12_q[8*lane_hi +: 8]));
            p_d    = p_q + 2'd1;
            if (p_q == 2'd3) begin
               state_d = S_ACT1;
            end
         end
         S_ACT1: begin
            h0_d    = h0_act;
            h1_d    = h1_act;
            state_d = S_L2;
         end
         S_L2: begin
            acc2_d  = sext8(w21_q[8*L2_BIAS_LANE +: 8])
                    + sext17(mul_u8s8(h0_q, w21_q[7:0]))
                    + sext17(mul_u8s8(h1_q, w21_q[15:8]));
            state_d = S_ACT2;
         end
         S_ACT2: begin
            out_d   = out_act;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // datapath registers and start edge detector
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_q     <= '0;
         start_q <= 1'b0;
         x_q     <= '0;
         w11_q   <= '0;
         w12_q   <= '0;
         w21_q   <= '0;
         acc0_q  <= '0;
         acc1_q  <= '0;
         acc2_q  <= '0;
         h0_q    <= '0;
         h1_q    <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         p_q     <= p_d;
         start_q <= start;
         x_q     <= x_d;
         w11_q   <= w11_d;
         w12_q   <= w12_d;
         w21_q   <= w21_d;
         acc0_q  <= acc0_d;
         acc1_q  <= acc1_d;
         acc2_q  <= acc2_d;
         h0_q    <= h0_d;
         h1_q    <= h1_d;
         out_q   <= out_d;
         done_q  <= done_d;
      end
   end

   assign data_out = out_q;
   assign done     = done_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mlp_serial_core.sv
// tb_mlp_serial_core: directed and randomised checks of mlp_serial_core
// against a request-level arithmetic model of the 7-2-1 perceptron.
module tb_mlp_serial_core;

   localparam int QS = 4;

`ifdef MLP_CORE_SATURATE_EN
   localparam int SAT_H = 255;
   localparam int SAT_Y = 31;
`else
   localparam int SAT_H = 96;
   localparam int SAT_Y = 12;
`endif

   localparam logic [55:0] X16  = {7{8'd16}};
   localparam logic [55:0] X255 = {7{8'd255}};
   localparam logic [63:0] W2   = {8'd0, {7{8'd2}}};
   localparam logic [63:0] W1   = {8'd0, {7{8'd1}}};
   localparam logic [63:0] WNEG = {8'd0, {7{8'hFF}}};
   localparam logic [63:0] WSAT = {8{8'h7F}};
   localparam logic [23:0] V16  = 24'h001010;
   localparam logic [23:0] V1   = 24'h000101;

   logic        clk;
   logic        rst;
   logic        start;
   logic [55:0] data_in;
   logic [63:0] data_weight_1_1;
   logic [63:0] data_weight_1_2;
   logic [23:0] data_weight_2_1;
   logic [7:0]  data_out;
   logic        done;
   logic        busy;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // request-level model state
   int m_cnt  = 0;
   bit m_prev = 1'b0;
   bit m_done = 1'b0;
   int m_out  = 0;
   int m_res  = 0;

   mlp_serial_core #(.QSHIFT(QS), .ACC_W(20)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .data_in         (data_in),
      .data_weight_1_1 (data_weight_1_1),
      .data_weight_1_2 (data_weight_1_2),
      .data_weight_2_1 (data_weight_2_1),
      .data_out        (data_out),
      .done            (done),
      .busy            (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sb(input logic [7:0] b);
      logic signed [7:0] t;
      t = b;
      return int'(t);
   endfunction

   function automatic int act(input int a);
      int s;
      if (a < 0) return 0;
      s = a / (1 << QS);
`ifdef MLP_CORE_SATURATE_EN
      return (s > 255) ? 255 : s;
`else
      return s % 256;
`endif
   endfunction

   function automatic int neuron1(input logic [55:0] x, input logic [63:0] w);
      int a;
      a = sb(w[63:56]);
      for (int k = 0; k < 7; k++) a += int'(x[8*k +: 8]) * sb(w[8*k +: 8]);
      return act(a);
   endfunction

   function automatic int model_y(input logic [55:0] x, input logic [63:0] a,
                                  input logic [63:0] b, input logic [23:0] c);
      return act(sb(c[23:16]) + sb(c[7:0]) * neuron1(x, a) + sb(c[15:8]) * neuron1(x, b));
   endfunction

   // model: an accepted request yields its result and a done pulse 7 clocks later
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_cnt  = 0;
         m_prev = 1'b0;
         m_done = 1'b0;
         m_out  = 0;
      end else begin
         m_done = 1'b0;
         if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_done = 1'b1;
               m_out  = m_res;
            end
         end else if (start && !m_prev) begin
            m_res = model_y(data_in, data_weight_1_1, data_weight_1_2, data_weight_2_1);
            m_cnt = 7;
         end
         m_prev = start;
      end
   end

   // per-cycle comparison of DUT outputs with the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("cmp_done", 32'(done), 32'(m_done));
         check("cmp_busy", 32'(busy), 32'(m_cnt > 0));
         check("cmp_data_out", 32'(data_out), 32'(m_out));
      end
   end

   task automatic run_req(input logic [55:0] x, input logic [63:0] a, input logic [63:0] b,
                          input logic [23:0] c, input int hold, input bit glitch,
                          output int lat, output int busy_cnt, output int done_cnt,
                          output logic [7:0] res);
      @(negedge clk);
      data_in         = x;
      data_weight_1_1 = a;
      data_weight_1_2 = b;
      data_weight_2_1 = c;
      start           = 1'b1;
      lat = -1; busy_cnt = 0; done_cnt = 0; res = '0;
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         if (i == 1) begin
            data_in         = 56'({$urandom, $urandom});
            data_weight_1_1 = {$urandom, $urandom};
            data_weight_1_2 = {$urandom, $urandom};
            data_weight_2_1 = 24'($urandom);
         end
         if (glitch && i == 2) start = 1'b0;
         if (glitch && i == 3) start = 1'b1;
         if (i == hold) start = 1'b0;
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (lat < 0) begin
               lat = i - 1;
               res = data_out;
            end
         end
      end
      start = 1'b0;
   endtask

   initial begin
      int lat, bc, dc, ndone;
      logic [7:0] res;

      start = 1'b0;
      data_in = '0;
      data_weight_1_1 = '0;
      data_weight_1_2 = '0;
      data_weight_2_1 = '0;
      rst = 1'b1;
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_data_out", 32'(data_out), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      rst = 1'b1;
      chk_en = 1'b1;

      // model pinned to hand-computed values
      check("model_h0_basic", 32'(neuron1(X16, W2)), 32'd14);
      check("model_h1_basic", 32'(neuron1(X16, W1)), 32'd7);
      check("model_basic", 32'(model_y(X16, W2, W1, V16)), 32'd21);
      check("model_relu", 32'(model_y(X16, WNEG, W1, V16)), 32'd7);
      check("model_sat", 32'(model_y(X255, WSAT, WSAT, V1)), 32'(SAT_Y));

      // basic path
      run_req(X16, W2, W1, V16, 4, 1'b0, lat, bc, dc, res);
      check("basic_latency", 32'(lat), 32'd7);
      check("basic_busy_cycles", 32'(bc), 32'd7);
      check("basic_done_count", 32'(dc), 32'd1);
      check("basic_data_out", 32'(res), 32'd21);
      check("basic_h0", 32'(dut.h0_q), 32'd14);
      check("basic_h1", 32'(dut.h1_q), 32'd7);

      // ReLU clips the negative hidden neuron
      run_req(X16, WNEG, W1, V16, 4, 1'b0, lat, bc, dc, res);
      check("relu_data_out", 32'(res), 32'd7);
      check("relu_h0", 32'(dut.h0_q), 32'd0);
      check("relu_h1", 32'(dut.h1_q), 32'd7);

      // saturation / wrap at the hidden layer
      run_req(X255, WSAT, WSAT, V1, 4, 1'b0, lat, bc, dc, res);
      check("sat_h0", 32'(dut.h0_q), 32'(SAT_H));
      check("sat_h1", 32'(dut.h1_q), 32'(SAT_H));
      check("sat_data_out", 32'(res), 32'(SAT_Y));

      // start held 12 cycles with an extra rising edge while busy
      run_req(X16, W2, W1, V16, 12, 1'b1, lat, bc, dc, res);
      check("retrig_done_count", 32'(dc), 32'd1);
      check("retrig_latency", 32'(lat), 32'd7);
      check("retrig_data_out", 32'(res), 32'd21);

      // reset in the middle of a request, with a non-zero data_out beforehand
      run_req(X16, W2, W1, V16, 4, 1'b0, lat, bc, dc, res);
      @(negedge clk);
      data_in = X16; data_weight_1_1 = W2; data_weight_1_2 = W1; data_weight_2_1 = V16;
      start = 1'b1;
      @(posedge clk);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_h0", 32'(dut.h0_q), 32'd0);
      @(negedge clk);
      start = 1'b0;
      rst = 1'b1;
      run_req(X16, W2, W1, V16, 4, 1'b0, lat, bc, dc, res);
      check("post_rst_latency", 32'(lat), 32'd7);
      check("post_rst_data_out", 32'(res), 32'd21);

      // back-to-back random requests, 4 high / 4 low
      ndone = 0;
      for (int r = 0; r < 64; r++) begin
         for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (done) ndone++;
            if (j == 0) begin
               data_in         = 56'({$urandom, $urandom});
               data_weight_1_1 = {$urandom, $urandom};
               data_weight_1_2 = {$urandom, $urandom};
               data_weight_2_1 = 24'($urandom);
               start           = 1'b1;
            end
            if (j == 2) begin
               data_in         = 56'({$urandom, $urandom});
               data_weight_1_1 = {$urandom, $urandom};
               data_weight_1_2 = {$urandom, $urandom};
               data_weight_2_1 = 24'($urandom);
            end
            if (j == 4) start = 1'b0;
         end
      end
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("b2b_done_count", 32'(ndone), 32'd64);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mlp_serial_core.md
# mlp_serial_core

Compute core that answers the `start`/`done` batch protocol issued by the MLP driver and bench. Per request it evaluates a 7-2-1 perceptron: 7 unsigned input bytes, 2 hidden neurons, 1 output neuron, with ReLU and requantisation at every neuron. Hidden-layer MACs run two inputs per neuron per cycle, so a result is ready inside one 8-cycle request slot. The core sits between the weight/data registers and the result capture logic.

## Interface
- `QSHIFT`, default 4: arithmetic right shift applied after ReLU at every neuron.
- `ACC_W`, default 20: signed accumulator width; must be ≥ 19.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request. Only its rising edge (start=1 while the internal `start_q`=0) is acted on.
- `data_in`  in  56  bits [8k+7:8k] = x_k for k=0..6; unsigned.
- `data_weight_1_1`  in  64  hidden neuron 0. Bytes 0..6 = w_k, byte 7 = bias; all signed.
- `data_weight_1_2`  in  64  hidden neuron 1; same layout as `data_weight_1_1`.
- `data_weight_2_1`  in  24  output neuron. Byte0 = weight for h0, byte1 = weight for h1, byte2 = bias; all signed.
- `data_out`  out  8  result, unsigned; holds until the next result or reset.
- `done`  out  1  one-cycle pulse; `data_out` is valid in that cycle.
- `busy`  out  1  high from the capture edge through the cycle before `done`.

## Operation
- States: IDLE, L1, ACT1, L2, ACT2.
- IDLE → L1 on a `start` rising edge.
  - Capture all inputs and weights.
  - Preload `acc0`/`acc1` with sign-extended bias bytes.
  - Clear pair index p.
- L1, p=0..3: each accumulator adds the two products of inputs (2p, 2p+1). At p=3 the second product is 0 because x7 does not exist. Move to ACT1 after p=3.
- ACT1: `h0`/`h1` = act(`acc0`/`acc1`).
- L2: `acc2` = bias2 + w0·h0 + w1·h1.
- ACT2: `data_out` = act(`acc2`), `done`=1, then return to IDLE.
- act(a): if a<0 the result is 0; else s = a>>>QSHIFT, then the `MLP_CORE_SATURATE_EN` rule applies.
- Products are u8 × s8, signed, 17 bits, extended to ACC_W; there is no overflow at ACC_W ≥ 19.
- A `start` rising edge while `busy`=1 is ignored. It is not queued.
- `start` held high across the `done` cycle does not retrigger.
- Inputs may change after the capture edge without affecting the result.

## Timing
- Reset values: `data_out`=0, `done`=0, `busy`=0, state IDLE, all accumulators and `h0`/`h1` = 0, `start_q`=0.
- Capture edge E0; L1 on E1–E4; ACT1 on E5; L2 on E6; ACT2 on E7.
- `done` is high in the cycle after E7: latency is 7 clocks from the sampled rising edge.
- Minimum spacing between accepted requests is 8 clocks, because `start` must fall and rise again.
- `rst` low at any point aborts immediately; outputs return to reset values asynchronously.

## Configuration
- `MLP_CORE_SATURATE_EN` defined: s>255 clamps to 255.
- Undefined: keep the low 8 bits of s, so the result wraps.
- The macro affects all three neurons identically.

## Structure
- Package `mlp_pkg` holds:
  - the state enum;
  - the `ACC_W`/`QSHIFT` defaults;
  - byte-lane constants: N_IN=7, bias lane 7 for layer 1, bias lane 2 for layer 2.
- Sub-module `mlp_act`: combinational ReLU + shift + saturate/wrap, instantiated three times (h0, h1, out).

## Test plan
- Basic path:
  - Stimulus: x all 16; w1_1 and w1_2 all weights 2 and 1, biases 0; w2_1 = {0,16,16}.
  - Response: h0=14, h1=7, `data_out`=21; `done` exactly 7 clocks after the start edge; `busy` high for 7 cycles.
- ReLU:
  - Stimulus: as the basic path, but w1_1 weights all 0xFF (−1).
  - Response: h0=0, `data_out`=7.
- Saturation:
  - Stimulus: x all 255; both hidden weight sets all 0x7F including bias; w2_1 = {0,1,1}.
  - Response with the macro defined: h=255, `data_out`=31.
  - Response with the macro undefined: h=96, `data_out`=12.
- Retrigger:
  - Stimulus: `start` held high 12 cycles; also a second rising edge at E3.
  - Response: exactly one `done` pulse; the result matches the first capture.
- Reset mid-operation:
  - Stimulus: `rst` low at E3.
  - Response: `busy`=0, `done`=0, `data_out`=0 immediately.
  - Follow-up: the next request completes normally with the basic-path value 21.
- Back-to-back: 64 requests with a 4-high/4-low `start` pattern, each result checked against the software model.
